fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the pipelined core: owns the program counter, issues word fetches to instruction memory over a valid/ready request / valid response interface, buffers up to two returned instructions, and presents them with their PC to the control code generator / decode stage as `inst_CCD`. It handles decode backpressure, branch/jump redirects that arrive while a fetch is in flight, and substitutes a NOP whenever no instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000: PC of the first fetch after reset.
- `NOP_INST`, 32'h0000_0013: word driven on `inst_CCD` when no instruction is valid (ADDI x0,x0,0).
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: IMEM accepts the request this cycle.
- `imem_addr` out 32: word-aligned fetch address (bits [1:0] always 0).
- `imem_rsp_valid` in 1: response valid; no backpressure. Exactly one response per accepted request, in order.
- `imem_rsp_data` in 32: fetched instruction.
- `inst_CCD` out 32: instruction to decode/CCG (FIFO head, or `NOP_INST` when empty).
- `pc_CCD` out 32: PC of `inst_CCD`; 0 when invalid.
- `inst_valid` out 1: `inst_CCD` is a real instruction.
- `dec_ready` in 1: decode consumes the head when `inst_valid && dec_ready`.
- `redirect_valid` in 1: branch/jump taken; pulse.
- `redirect_pc` in 32: new fetch target.
- `misalign_err` out 1: one-cycle pulse when `redirect_pc[1:0] != 0`.

## Operation
- Registers: `pc` (next fetch address), `outstanding` (0/1), `drop` (discard next response), 2-entry FIFO of {inst, pc}, `count` 0..2.
- At most one request outstanding.
- Request rule: `imem_req_valid = !rst && !redirect_valid && (!outstanding || imem_rsp_valid) && (count + outstanding − deq) < 2`, where deq = `inst_valid && dec_ready`. `imem_addr = pc`.
- Request accepted (valid && ready): `outstanding <= 1`, `pc <= pc + 4` (mod 2^32, wraps 0xFFFF_FFFC → 0).
- Response with `outstanding == 1`: `outstanding <= 0` unless a new request is accepted the same cycle. If `drop`, discard and clear `drop`; else enqueue {data, address of that request}.
- Response with `outstanding == 0` (stale, e.g. across reset): ignored.
- Enqueue and dequeue in the same cycle: both happen, `count` unchanged.
- Redirect (highest priority): FIFO flushed (`count <= 0`), any same-cycle dequeue/enqueue suppressed, `pc <= {redirect_pc[31:2], 2'b00}`, `misalign_err <= |redirect_pc[1:0]`. If a request is outstanding and its response is not arriving this cycle, `drop <= 1`. No request is issued in the redirect cycle; fetch from the new PC starts the next cycle.
- Back-to-back redirects: the last one wins; `drop` stays set until a single response is discarded.

## Timing
- Reset values: `pc = RESET_PC`, `outstanding = 0`, `drop = 0`, `count = 0`, `inst_valid = 0`, `inst_CCD = NOP_INST`, `pc_CCD = 0`, `imem_req_valid = 0` while `rst` is high, `misalign_err = 0`.
- The first request is asserted in the first cycle after `rst` falls.
- Latency: a response in cycle N gives `inst_valid = 1` in cycle N+1.
- Throughput: 1 instruction/cycle when IMEM answers one cycle after acceptance and `dec_ready = 1`.
- `inst_CCD`, `pc_CCD`, and `inst_valid` are registered FIFO outputs. `imem_req_valid` is combinational from `imem_rsp_valid`, `dec_ready`, and `redirect_valid`.
- Reset mid-fetch: all state clears, and a late response is ignored per the stale rule.

## Structure
- Shared package `core_pkg`: `NOP_INST`, `XLEN = 32`, `fetch_entry_t` struct {inst, pc}.
- Sub-module `fetch_fifo`: 2-entry, synchronous-flush FIFO of `fetch_entry_t`, with push/pop/flush/count. `fetch_unit` holds the PC, outstanding/drop, and request logic.

## Test plan
- Reset: hold `rst` 3 cycles with random inputs → all outputs at reset values, `imem_req_valid = 0`; first request after reset has `imem_addr = RESET_PC`.
- Streaming, zero-wait IMEM, `dec_ready = 1` → `pc_CCD` = 0x0, 0x4, 0x8, 0xC on consecutive cycles, with data matching IMEM.
- Backpressure: `dec_ready = 0` for 4 cycles → `count` reaches 2, then no requests; release gives 0x0, 0x4, 0x8 in order with no loss or duplication.
- Redirect during outstanding fetch: request 0x8 accepted, `redirect_valid` with 0x200 before the response → 0x8 response discarded, next `imem_addr = 0x200`, FIFO empty, `inst_CCD = 0x0000_0013`.
- Misaligned redirect with `redirect_pc = 0x102` → fetch at 0x100, `misalign_err` high for exactly one cycle.
- Simultaneous redirect and response with `count = 1`, `dec_ready = 1` → FIFO flushed, no dequeue, `drop` stays 0, next fetch at the redirect target.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage and its buffer.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    // ADDI x0,x0,0: presented to decode whenever no real instruction is buffered.
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer; the head register drives decode directly and
// holds {NOP_INST, 0} whenever the buffer is empty.
module fetch_fifo
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    localparam fetch_entry_t EMPTY = '{inst: NOP_INST, pc: '0};

    fetch_entry_t tail;
    logic         do_pop;
    logic         do_push;

    assign valid   = (count != 2'd0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((count != 2'd2) || do_pop);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; tail is deliberately left out of reset because
    // count alone decides whether its payload is meaningful.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
            head  <= EMPTY;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_entry;
                    else               tail <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= (count == 2'd2) ? tail : EMPTY;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_entry;
                    end else begin
                        head <= tail;
                        tail <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one IMEM request in flight, and
// discards the response of a fetch overtaken by a redirect.
module fetch_unit
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] inst_CCD,
    output logic [XLEN-1:0] pc_CCD,
    output logic            inst_valid,
    input  logic            dec_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misalign_err
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            outstanding;
    logic            drop;
    logic [1:0]      count;
    logic            deq;
    logic            accept;
    logic            rsp_live;
    logic [2:0]      occupancy;
    fetch_entry_t    head;
    fetch_entry_t    rsp_entry;

    assign deq       = inst_valid && dec_ready;
    // Slots already committed: buffered entries plus the in-flight fetch.
    assign occupancy = {1'b0, count} + {2'b00, outstanding} - {2'b00, deq};

    assign imem_req_valid = !rst && !redirect_valid
                          && (!outstanding || imem_rsp_valid)
                          && (occupancy < 3'd2);
    assign imem_addr = pc;
    assign accept    = imem_req_valid && imem_req_ready;
    assign rsp_live  = imem_rsp_valid && outstanding;
    assign rsp_entry = '{inst: imem_rsp_data, pc: req_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            req_pc       <= RESET_PC;
            outstanding  <= 1'b0;
            drop         <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (|redirect_pc[1:0]);

            if (accept) begin
                outstanding <= 1'b1;
                req_pc      <= pc;
            end else if (rsp_live) begin
                outstanding <= 1'b0;
            end

            if (redirect_valid) begin
                pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (accept) begin
                pc <= pc + 32'd4;
            end

            // Consecutive redirects keep one drop pending: only one stale response exists.
            if (redirect_valid && outstanding && !imem_rsp_valid) begin
                drop <= 1'b1;
            end else if (rsp_live) begin
                drop <= 1'b0;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (rsp_live && !drop && !redirect_valid),
        .push_entry (rsp_entry),
        .pop        (deq && !redirect_valid),
        .head       (head),
        .valid      (inst_valid),
        .count      (count)
    );

    assign inst_CCD = head.inst;
    assign pc_CCD   = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table driven against a
// one-cycle-latency IMEM model, plus hand-written reset sequences.
module tb_fetch_unit;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst_CCD;
    logic [31:0] pc_CCD;
    logic        inst_valid;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_CCD       (inst_CCD),
        .pc_CCD         (pc_CCD),
        .inst_valid     (inst_valid),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // IMEM model state: one pending response, returned when enabled.
    bit          rsp_pending = 1'b0;
    logic [31:0] rsp_addr    = 32'h0;

    typedef struct {
        bit          dec;
        bit          rdy;
        bit          rsp_en;
        bit          redir;
        logic [31:0] rpc;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
        bit          exp_mis;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic vec_t mk(input int d, input int r, input int e, input int rd,
                                input logic [31:0] rpc, input int xr, input logic [31:0] xa,
                                input int xv, input logic [31:0] xp, input int xm);
        vec_t m;
        m.dec       = (d != 0);
        m.rdy       = (r != 0);
        m.rsp_en    = (e != 0);
        m.redir     = (rd != 0);
        m.rpc       = rpc;
        m.exp_req   = (xr != 0);
        m.exp_addr  = xa;
        m.exp_valid = (xv != 0);
        m.exp_pc    = xp;
        m.exp_mis   = (xm != 0);
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit xv, input logic [31:0] xp, input bit xm);
        check({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, xv});
        check({tag, " pc_CCD"}, pc_CCD, xv ? xp : 32'h0);
        check({tag, " inst_CCD"}, inst_CCD, xv ? mem_word(xp) : NOP_INST);
        check({tag, " misalign_err"}, {31'b0, misalign_err}, {31'b0, xm});
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        bit          acc;
        logic [31:0] acc_addr;
        tag            = $sformatf("vec%0d", idx);
        dec_ready      = v.dec;
        imem_req_ready = v.rdy;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        imem_rsp_valid = rsp_pending && v.rsp_en;
        imem_rsp_data  = imem_rsp_valid ? mem_word(rsp_addr) : 32'h0BAD_0BAD;
        #1;
        check({tag, " req_valid"}, {31'b0, imem_req_valid}, {31'b0, v.exp_req});
        if (v.exp_req) check({tag, " imem_addr"}, imem_addr, v.exp_addr);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;
        @(posedge clk);
        if (imem_rsp_valid) rsp_pending = 1'b0;
        if (acc) begin
            rsp_pending = 1'b1;
            rsp_addr    = acc_addr;
        end
        @(negedge clk);
        check_outputs(tag, v.exp_valid, v.exp_pc, v.exp_mis);
    endtask

    initial begin
        // Columns: dec, rdy, rsp_en, redir, rpc | req, addr | valid, pc, mis
        // Streaming from reset.
        vecs[0]  = mk(1,1,1,0,32'h0,        1,32'h0,        0,32'h0,        0);
        vecs[1]  = mk(1,1,1,0,32'h0,        1,32'h4,        1,32'h0,        0);
        vecs[2]  = mk(1,1,1,0,32'h0,        1,32'h8,        1,32'h4,        0);
        vecs[3]  = mk(1,1,1,0,32'h0,        1,32'hC,        1,32'h8,        0);
        vecs[4]  = mk(1,1,1,0,32'h0,        1,32'h10,       1,32'hC,        0);
        // Decode stalls four cycles: buffer fills, requests stop.
        vecs[5]  = mk(0,1,1,0,32'h0,        0,32'h0,        1,32'hC,        0);
        vecs[6]  = mk(0,1,1,0,32'h0,        0,32'h0,        1,32'hC,        0);
        vecs[7]  = mk(0,1,1,0,32'h0,        0,32'h0,        1,32'hC,        0);
        vecs[8]  = mk(0,1,1,0,32'h0,        0,32'h0,        1,32'hC,        0);
        vecs[9]  = mk(1,1,1,0,32'h0,        1,32'h14,       1,32'h10,       0);
        vecs[10] = mk(1,1,1,0,32'h0,        1,32'h18,       1,32'h14,       0);
        vecs[11] = mk(1,1,1,0,32'h0,        1,32'h1C,       1,32'h18,       0);
        // 0x1C held in flight, redirect to 0x200 before its response.
        vecs[12] = mk(1,1,0,0,32'h0,        0,32'h0,        0,32'h0,        0);
        vecs[13] = mk(1,1,0,1,32'h200,      0,32'h0,        0,32'h0,        0);
        vecs[14] = mk(1,1,1,0,32'h0,        1,32'h200,      0,32'h0,        0);
        vecs[15] = mk(1,1,1,0,32'h0,        1,32'h204,      1,32'h200,      0);
        vecs[16] = mk(1,1,1,0,32'h0,        1,32'h208,      1,32'h204,      0);
        // Misaligned redirect coinciding with a response, count 1, dec_ready 1.
        vecs[17] = mk(1,1,1,1,32'h102,      0,32'h0,        0,32'h0,        1);
        vecs[18] = mk(1,1,1,0,32'h0,        1,32'h100,      0,32'h0,        0);
        vecs[19] = mk(1,1,1,0,32'h0,        1,32'h104,      1,32'h100,      0);
        vecs[20] = mk(1,1,1,0,32'h0,        1,32'h108,      1,32'h104,      0);
        // Back-to-back redirects while 0x108 is in flight: last target wins.
        vecs[21] = mk(1,1,0,1,32'h300,      0,32'h0,        0,32'h0,        0);
        vecs[22] = mk(1,1,0,1,32'h400,      0,32'h0,        0,32'h0,        0);
        vecs[23] = mk(1,1,1,0,32'h0,        1,32'h400,      0,32'h0,        0);
        vecs[24] = mk(1,1,1,0,32'h0,        1,32'h404,      1,32'h400,      0);
        vecs[25] = mk(1,1,1,0,32'h0,        1,32'h408,      1,32'h404,      0);
        // IMEM refuses one request.
        vecs[26] = mk(1,0,1,0,32'h0,        1,32'h40C,      1,32'h408,      0);
        vecs[27] = mk(1,1,1,0,32'h0,        1,32'h40C,      0,32'h0,        0);
        vecs[28] = mk(1,1,1,0,32'h0,        1,32'h410,      1,32'h40C,      0);
        // PC wrap at the top of the address space.
        vecs[29] = mk(1,1,1,1,32'hFFFF_FFFC,0,32'h0,        0,32'h0,        0);
        vecs[30] = mk(1,1,1,0,32'h0,        1,32'hFFFF_FFFC,0,32'h0,        0);
        vecs[31] = mk(1,1,1,0,32'h0,        1,32'h0,        1,32'hFFFF_FFFC,0);
        vecs[32] = mk(1,1,1,0,32'h0,        1,32'h4,        1,32'h0,        0);

        rst            = 1'b1;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);

        // Reset held three cycles under random inputs.
        for (int i = 0; i < 3; i++) begin
            dec_ready      = 1'($urandom_range(0, 1));
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc    = $urandom;
            #1;
            check($sformatf("reset%0d req_valid", i), {31'b0, imem_req_valid}, 32'h0);
            @(negedge clk);
            check_outputs($sformatf("reset%0d", i), 1'b0, 32'h0, 1'b0);
        end

        // First cycle out of reset: request at RESET_PC, stale response ignored.
        rst            = 1'b0;
        dec_ready      = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check("first req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("first imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        check("stale inst_valid", {31'b0, inst_valid}, 32'h0);
        check("stale inst_CCD", inst_CCD, NOP_INST);
        imem_rsp_valid = 1'b0;
        rsp_pending    = 1'b0;

        for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

        // Reset while 0x4 is in flight; its late response must be ignored.
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        check_outputs("midreset", 1'b0, 32'h0, 1'b0);
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'h4);
        #1;
        check("midreset req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("midreset imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        check("late rsp inst_valid", {31'b0, inst_valid}, 32'h0);
        check("late rsp inst_CCD", inst_CCD, NOP_INST);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
